vid_sram_banked: RTL and testbench

- Parametrised successor to the team's single-port vid SRAM simulation model.
- Generalised in depth, lane count and lane width.
- Adds per-lane write masking, a configurable read-latency pipeline with a valid flag, read-enable gating, out-of-range protection and same-address collision reporting.
- Sits between the batch scheduler and the vid consumers; also serves as the reusable model for all lane-organised SRAMs in the sim tree.

---
 rtl/vid_sram_banked.sv | 132 +++++++++++++
 tb/tb_vid_sram_banked.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vid_sram_banked.sv
// Lane-organised dual-port SRAM model with per-lane write mask and an RD_LAT-deep read pipeline.
// Define VID_SRAM_RDW_FWD_EN to forward same-address write data to a read in the same cycle; otherwise reads are read-first.
module vid_sram_banked #(
    parameter int DEPTH      = 16,
    parameter int ADDR_SPACE = 4,
    parameter int Q          = 16,
    parameter int VID_BW     = 16,
    parameter int RD_LAT     = 1,
    parameter int OUT_DLY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wsb,
    input  logic [Q-1:0]          wmask,
    input  logic [ADDR_SPACE-1:0] waddr,
    input  logic [VID_BW*Q-1:0]   wdata,
    input  logic                  rsb,
    input  logic [ADDR_SPACE-1:0] raddr,
    output logic [VID_BW*Q-1:0]   rdata,
    output logic                  rvalid,
    output logic                  collision,
    output logic                  oob_err
);

    localparam int W  = VID_BW * Q;
    localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_SPACE:0] DEPTH_A = (ADDR_SPACE + 1)'(DEPTH);

    // OUT_DLY is a timing annotation for the behavioural sim tree; the synthesizable outputs are not delayed.
    if (RD_LAT < 1 || RD_LAT > 4 || DEPTH < 2 || (2 ** ADDR_SPACE) < DEPTH || OUT_DLY < 0) begin : g_param_check
        $error("vid_sram_banked: illegal parameter combination");
    end

    logic [W-1:0] mem [DEPTH];

    logic         rd_en;
    logic         wr_req;
    logic         rd_in_range;
    logic         wr_in_range;
    logic         wr_en;
    logic         same_addr;
    logic [W-1:0] rd_cur;
    logic [W-1:0] wr_cur;
    logic [W-1:0] wr_word;
    logic [W-1:0] rd_word;

    logic [W-1:0]      pipe_data [RD_LAT];
    logic [RD_LAT-1:0] pipe_vld;

    assign rd_en       = ~rsb;
    assign wr_req      = ~wsb;
    assign rd_in_range = ({1'b0, raddr} < DEPTH_A);
    assign wr_in_range = ({1'b0, waddr} < DEPTH_A);
    assign wr_en       = wr_req & wr_in_range;
    assign same_addr   = (raddr == waddr);

    assign rd_cur = mem[raddr[IW-1:0]];
    assign wr_cur = mem[waddr[IW-1:0]];

    always_comb begin
        wr_word = wr_cur;
        for (int i = 0; i < Q; i++) begin
            if (wmask[i]) begin
                wr_word[i*VID_BW +: VID_BW] = wdata[i*VID_BW +: VID_BW];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
`ifdef VID_SRAM_RDW_FWD_EN
            rd_word = (wr_en && same_addr) ? wr_word : rd_cur;
`else
            rd_word = rd_cur;
`endif
        end
    end

    // Array is deliberately outside the reset domain so contents survive rst_n.
    always @(posedge clk) begin
        if (wr_en) begin
            mem[waddr[IW-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_data[s] <= '0;
            end
            pipe_vld  <= '0;
            collision <= 1'b0;
            oob_err   <= 1'b0;
        end else begin
            pipe_vld[0] <= rd_en;
            if (rd_en) begin
                pipe_data[0] <= rd_word;
            end
            // Data only advances behind a valid token, so bubbles leave rdata holding its last result.
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                if (pipe_vld[s-1]) begin
                    pipe_data[s] <= pipe_data[s-1];
                end
            end
            collision <= rd_en & wr_req & rd_in_range & same_addr;
            oob_err   <= (rd_en & ~rd_in_range) | (wr_req & ~wr_in_range);
        end
    end

    assign rdata  = pipe_data[RD_LAT-1];
    assign rvalid = pipe_vld[RD_LAT-1];

    task automatic load_param(input int index, input logic [W-1:0] data);
        if (index < 0 || index >= DEPTH) begin
            $display("vid_sram_banked: load_param index %0d out of range, ignored", index);
        end else begin
            mem[IW'(index)] <= data;
        end
    endtask

    task automatic dump_word(input int index, output logic [W-1:0] data);
        data = '0;
        if (index < 0 || index >= DEPTH) begin
            $display("vid_sram_banked: dump_word index %0d out of range, ignored", index);
        end else begin
            data = mem[IW'(index)];
        end
    endtask

endmodule

// File: tb/tb_vid_sram_banked.sv
// Scoreboard bench for vid_sram_banked: DEPTH=12 exercises out-of-range, RD_LAT=3 exercises the pipeline.
module tb_vid_sram_banked;

    localparam int DEPTH      = 12;
    localparam int ADDR_SPACE = 4;
    localparam int Q          = 16;
    localparam int VID_BW     = 16;
    localparam int RD_LAT     = 3;
    localparam int W          = VID_BW * Q;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  wsb;
    logic [Q-1:0]          wmask;
    logic [ADDR_SPACE-1:0] waddr;
    logic [W-1:0]          wdata;
    logic                  rsb;
    logic [ADDR_SPACE-1:0] raddr;
    logic [W-1:0]          rdata;
    logic                  rvalid;
    logic                  collision;
    logic                  oob_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] mem_m [DEPTH];
    logic [W-1:0] exp_q [$];
    logic         vld_q [$];
    logic [W-1:0] hold_exp;

    vid_sram_banked #(
        .DEPTH(DEPTH), .ADDR_SPACE(ADDR_SPACE), .Q(Q), .VID_BW(VID_BW), .RD_LAT(RD_LAT), .OUT_DLY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wsb(wsb), .wmask(wmask), .waddr(waddr), .wdata(wdata),
        .rsb(rsb), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .collision(collision), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [VID_BW-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < Q; i++) r[i*VID_BW +: VID_BW] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                           input logic [Q-1:0] m);
        logic [W-1:0] r;
        r = old_w;
        for (int i = 0; i < Q; i++) if (m[i]) r[i*VID_BW +: VID_BW] = new_w[i*VID_BW +: VID_BW];
        return r;
    endfunction

    task automatic sb_clear();
        exp_q.delete();
        vld_q.delete();
        for (int i = 0; i < RD_LAT - 1; i++) vld_q.push_back(1'b0);
        hold_exp = '0;
    endtask

    task automatic backdoor_load(input int idx, input logic [W-1:0] d);
        dut.load_param(idx, d);
        mem_m[idx] = d;
    endtask

    // One clock: drive, update the model, then check outputs 1 time unit after the edge.
    task automatic cycle(input logic rd, input int ra, input logic wr, input int wa,
                         input logic [Q-1:0] wm, input logic [W-1:0] wd);
        logic         rd_in, wr_in, exp_col, exp_oob, ev;
        logic [W-1:0] exp_rd;
        rsb   = ~rd;
        raddr = ADDR_SPACE'(ra);
        wsb   = ~wr;
        waddr = ADDR_SPACE'(wa);
        wmask = wm;
        wdata = wd;
        rd_in   = (ra < DEPTH);
        wr_in   = (wa < DEPTH);
        exp_col = rd && wr && rd_in && (ra == wa);
        exp_oob = (rd && !rd_in) || (wr && !wr_in);
        if (rd) begin
            exp_rd = rd_in ? mem_m[ra] : '0;
`ifdef VID_SRAM_RDW_FWD_EN
            if (exp_col) exp_rd = merge(mem_m[ra], wd, wm);
`endif
            exp_q.push_back(exp_rd);
        end
        if (wr && wr_in) mem_m[wa] = merge(mem_m[wa], wd, wm);
        @(posedge clk);
        #1;
        vld_q.push_back(rd);
        ev = vld_q.pop_front();
        check("rvalid", W'(rvalid), W'(ev));
        if (ev) begin
            check("sb_underflow", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) hold_exp = exp_q.pop_front();
        end
        check("rdata", rdata, hold_exp);
        check("collision", W'(collision), W'(exp_col));
        check("oob_err", W'(oob_err), W'(exp_oob));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0, '0, '0);
    endtask

    task automatic reset_pulse();
        rsb   = 1'b1;
        wsb   = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_rdata", rdata, '0);
        check("rst_rvalid", W'(rvalid), '0);
        check("rst_collision", W'(collision), '0);
        check("rst_oob", W'(oob_err), '0);
        sb_clear();
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] dw;
        rst_n = 1'b0;
        rsb   = 1'b1;
        wsb   = 1'b1;
        wmask = '0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
        sb_clear();
        for (int i = 0; i < DEPTH; i++) begin
            for (int l = 0; l < Q; l++) dw[l*VID_BW +: VID_BW] = VID_BW'($urandom);
            backdoor_load(i, dw);
        end
        #13;
        check("init_rdata", rdata, '0);
        check("init_rvalid", W'(rvalid), '0);
        check("init_collision", W'(collision), '0);
        check("init_oob", W'(oob_err), '0);
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Masked write then read back.
        backdoor_load(5, rep(16'hAAAA));
        #1;
        dut.dump_word(5, dw);
        check("backdoor_5", dw, rep(16'hAAAA));
        cycle(1'b0, 0, 1'b1, 5, 16'h00F0, rep(16'h1234));
        cycle(1'b1, 5, 1'b0, 0, '0, '0);
        idle(RD_LAT);
        dut.dump_word(5, dw);
        check("masked_word", dw, {{8{16'hAAAA}}, {4{16'h1234}}, {4{16'hAAAA}}});

        // Burst of reads 0..15 with one bubble after address 7.
        for (int a = 0; a < 16; a++) begin
            cycle(1'b1, a, 1'b0, 0, '0, '0);
            if (a == 7) idle(1);
        end
        idle(RD_LAT);

        // Same-address read/write, then back-to-back collisions incl. an empty-mask write.
        backdoor_load(3, rep(16'h0001));
        cycle(1'b1, 3, 1'b1, 3, '1, rep(16'h00FF));
        cycle(1'b1, 3, 1'b1, 3, '0, rep(16'h5555));
        cycle(1'b1, 3, 1'b1, 4, 16'h0003, rep(16'h6666));
        idle(RD_LAT);

        // Out-of-range write and read.
        cycle(1'b0, 0, 1'b1, 13, '1, rep(16'hDEAD));
        cycle(1'b1, 14, 1'b0, 0, '0, '0);
        cycle(1'b1, 15, 1'b1, 15, '1, rep(16'hDEAD));
        idle(RD_LAT);
        for (int i = 0; i < DEPTH; i++) begin
            dut.dump_word(i, dw);
            check($sformatf("mem_%0d", i), dw, mem_m[i]);
        end

        // Reset with two reads in flight, then quiet pipe.
        cycle(1'b1, 1, 1'b0, 0, '0, '0);
        cycle(1'b1, 2, 1'b0, 0, '0, '0);
        reset_pulse();
        idle(RD_LAT + 1);

        // Persistence across reset.
        cycle(1'b0, 0, 1'b1, 7, '1, rep(16'hBEEF));
        reset_pulse();
        cycle(1'b1, 7, 1'b0, 0, '0, '0);
        idle(RD_LAT);
        check("sb_leftover", W'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
